xor_descrambler: RTL
====================

Name: xor_descrambler

Overview:
- Receive-side counterpart of the team's registered XOR encoder.
- Recovers plain N-bit words from an additive-scrambled stream by XORing each accepted word with an internally generated LFSR keystream.
- The encoder side XORs with the same keystream, so payload = in_data ^ key.
- Sits between the link receive register and downstream consumers.
- Valid/ready handshake on both sides; one registered output stage.

Parameters:
- N, 4, data word width (1..32).
- LFSR_W, 16, keystream LFSR width.
- POLY, 16'hB400, Galois feedback mask, LFSR_W bits.
- SEED, 16'hACE1, reset state; also substituted for an all-zero seed load.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- seed_ld  in  1  load seed pulse
- seed  in  LFSR_W  seed value, sampled when seed_ld=1
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_data  in  N  scrambled word
- out_valid  out  1  output word valid
- out_ready  in  1  downstream ready
- out_data  out  N  descrambled word

Behaviour:
Reset (async, rst=1):
- state=IDLE, lfsr=SEED, out_valid=0, out_data=0.
- in_ready is 0 while rst=1.

LFSR step (Galois, right shift):
- Output bit = s[0].
- Next state = (s>>1) ^ (s[0] ? POLY : 0).

Keystream word:
- Bit i (i=0..N-1) is the output bit of step i, starting from the current lfsr.
- On acceptance, lfsr advances exactly N steps, all within one cycle (unrolled combinational).
- Steps are bit-serial, LSB of the word first.

States:
- IDLE: in_ready=0. On seed_ld, go to RUN.
- RUN: in_ready = !seed_ld & (!out_valid | out_ready).
  - An accept (in_valid & in_ready) registers out_data = in_data ^ key, sets out_valid=1, and advances lfsr by N steps.
- There is no return from RUN to IDLE except by reset.

Seed load (any state):
- lfsr <= (seed==0) ? SEED : seed.
- seed_ld has priority: no input is accepted in that cycle.
- A pending out_valid word is not affected and stays until consumed.

Output:
- Latency is 1 cycle from accept to out_valid.
- out_valid/out_data hold stable while out_valid & !out_ready.
- out_valid clears on a handshake unless a new word is accepted in the same cycle.
- Full throughput with out_ready held at 1: one word per cycle.

Boundaries:
- Simultaneous consume and accept: out_data is replaced and out_valid stays 1.
- lfsr never becomes zero: a nonzero state is guaranteed by the zero-seed substitution and the maximal-length POLY.
- Reset mid-stream: the pending word is discarded, lfsr returns to SEED, and the block requires a new seed_ld before accepting input.

Optional Feature:
XOR_DESCRAM_CNT_EN
- Defined:
  - Adds output port word_cnt [15:0].
  - word_cnt counts output handshakes (out_valid & out_ready).
  - Cleared to 0 by rst and by seed_ld.
  - Saturates at 16'hFFFF.
  - If seed_ld coincides with a handshake, the clear wins.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Known keystream: N=4, defaults. seed_ld with seed=0 (loads 16'hACE1), then in_data 4'h1 and 4'h0 on consecutive cycles, out_ready=1 -> out_data 4'h0 then 4'hE, each one cycle after accept, out_valid high both cycles.
- IDLE gating: after reset, in_valid=1 for 5 cycles with no seed_ld -> in_ready=0 and out_valid=0 throughout. Then seed_ld=1 for one cycle -> in_ready=1 on the following cycle.
- Backpressure: after a seed of 16'hACE1, accept 4'h5; hold out_ready=0 for 3 cycles -> out_data=4'h4 stable, in_ready=0, no lfsr advance. Release, then send 4'hE -> out_data 4'h0.
- seed_ld collision: seed_ld=1 with seed=16'hACE1 while in_valid=1 with 4'h1 -> not accepted that cycle. The same word is accepted next cycle -> out_data 4'h0.
- Async reset mid-stream: assert rst between clock edges while out_valid=1 -> out_valid and out_data go to 0 immediately, without a clock edge. After release and reseed, the first word 4'h1 -> 4'h0.
- Counter (XOR_DESCRAM_CNT_EN):
  - 3 handshakes -> word_cnt=3.
  - seed_ld -> 0.
  - Force 65540 handshakes -> word_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/xor_descrambler.sv
// -----------------------------------------------------------------------------
// xor_descrambler
//
// Receive-side additive descrambler. Each accepted N-bit word is XORed with
// N keystream bits taken from a Galois LFSR (right shift, LSB of the word
// first). Both sides use a valid/ready handshake, and there is one registered
// output stage. The block starts in IDLE and refuses input until it sees a
// seed load. After that it stays in RUN until the next reset.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   seed_ld    in   load seed pulse (has priority over input acceptance)
//   seed       in   [LFSR_W] seed value; a zero seed is replaced by SEED
//   in_valid   in   input word valid
//   in_ready   out  input word accepted when in_valid & in_ready
//   in_data    in   [N] scrambled word
//   out_valid  out  output word valid (registered)
//   out_ready  in   downstream ready
//   out_data   out  [N] descrambled word (registered)
//   word_cnt   out  [16] saturating output handshake count
//                   (only when XOR_DESCRAM_CNT_EN is defined)
//
// Optional feature macro: XOR_DESCRAM_CNT_EN
// -----------------------------------------------------------------------------
module xor_descrambler #(
  parameter int                N      = 4,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] POLY   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef XOR_DESCRAM_CNT_EN
  output logic [15:0]       word_cnt,
`endif
  output logic [N-1:0]      out_data
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              out_valid_q, out_valid_d;
  logic [N-1:0]      out_data_q, out_data_d;

  logic [N-1:0]      key_s;
  logic [LFSR_W-1:0] lfsr_adv_s;
  logic              accept_s;
  logic              in_ready_s;

  // Unrolled keystream: N Galois steps from the current state in one cycle.
  always_comb begin
    lfsr_adv_s = lfsr_q;
    key_s      = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      key_s[i]   = lfsr_adv_s[0];
      lfsr_adv_s = (lfsr_adv_s >> 1) ^ (lfsr_adv_s[0] ? POLY : {LFSR_W{1'b0}});
    end
  end

  // Input acceptance: a seed load blocks input, and the single output stage
  // may only be refilled when it is empty or is being drained this cycle.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      ST_IDLE: in_ready_s = 1'b0;
      ST_RUN:  in_ready_s = !seed_ld && (!out_valid_q || out_ready);
      default: in_ready_s = 1'b0;
    endcase
    accept_s = in_valid && in_ready_s;
  end

  // Next-state logic for the FSM, the LFSR and the output stage.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (seed_ld) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase

    // A zero seed would lock the LFSR, so SEED is substituted for it.
    if (seed_ld) begin
      lfsr_d = (seed == {LFSR_W{1'b0}}) ? SEED : seed;
    end else if (accept_s) begin
      lfsr_d = lfsr_adv_s;
    end else begin
      lfsr_d = lfsr_q;
    end

    // A same-cycle refill takes precedence over the drain of the old word.
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ key_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State, keystream and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= {N{1'b0}};
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef XOR_DESCRAM_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating handshake counter; a seed load clears it even on a handshake.
  always_comb begin
    cnt_d = cnt_q;
    if (seed_ld) begin
      cnt_d = 16'h0000;
    end else if (out_valid_q && out_ready && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'h0001;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign word_cnt = cnt_q;
`endif

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
